// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, prefetch queue feeding IF/ID, branch redirect with in-flight discard.
// Optional perf counters (fetch_count, discard_count) when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] PC,
  output logic [31:0] instruction
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] discard_count
`endif
);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  state_t        state;
  logic [31:0]   fetch_pc, req_pc;
  entry_t        q [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          issue, push, pop, drop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Issue only needs a free slot: with a single outstanding read, a kept response always fits.
  assign issue       = !rst && (state == IDLE) && (count < FULL) && !branch_taken;
  assign push        = (state == WAIT) && imem_rvalid && !branch_taken;
  assign drop        = imem_rvalid && ((state == DISCARD) || ((state == WAIT) && branch_taken));
  assign if_valid    = (count != '0);
  assign pop         = if_valid && !stall && !branch_taken;
  assign imem_req    = issue;
  assign imem_addr   = fetch_pc;
  assign PC          = if_valid ? q[rd_ptr].pc   : '0;
  assign instruction = if_valid ? q[rd_ptr].insn : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE:    if (issue) state <= WAIT;
        WAIT:    if (imem_rvalid) state <= IDLE;
                 else if (branch_taken) state <= DISCARD;
        DISCARD: if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (branch_taken) fetch_pc <= {branch_target[31:2], 2'b00};
      else if (issue)   fetch_pc <= fetch_pc + 32'd4;
      if (issue) req_pc <= fetch_pc;

      if (branch_taken) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= nxt(wr_ptr);
        if (pop)  rd_ptr <= nxt(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Entry storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= '{pc: req_pc + 32'd4, insn: imem_rdata};
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count   <= '0;
      discard_count <= '0;
    end else begin
      if (issue) fetch_count   <= fetch_count + 32'd1;
      if (drop)  discard_count <= discard_count + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic checked each cycle against a queue-based model.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_req, imem_rvalid, if_valid;
  logic [31:0] branch_target, imem_addr, imem_rdata, PC, instruction;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, discard_count;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .PC(PC), .instruction(instruction)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .discard_count(discard_count)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  // Model: words waiting for IF/ID, next fetch address, and what happens to the read in flight.
  ent_t        mq[$];
  mreq_t       memq[$];
  logic [31:0] m_fpc, m_rpc, m_fcnt, m_dcnt;
  int          m_out;  // 0: nothing in flight, 1: in flight and kept, 2: in flight and dropped
  int          lat = 1, cyc = 0, n_cmp = 0, n_err = 0;
  logic        chk_en = 1'b1;
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_pc, o_insn;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] tgt);
    logic        e_req, e_valid, keep, drp, popd;
    logic [31:0] e_pc, e_insn;
    rst = r; stall = s; branch_taken = b; branch_target = tgt;
    if (memq.size() != 0 && memq[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc   : 32'h0;
    e_insn  = e_valid ? mq[0].insn : 32'h0;
    e_req   = !r && (m_out == 0) && (mq.size() < DEPTH) && !b;
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", imem_addr, m_fpc);
      chk("if_valid", 32'(if_valid), 32'(e_valid));
      chk("PC", PC, e_pc);
      chk("instruction", instruction, e_insn);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fcnt);
      chk("discard_count", discard_count, m_dcnt);
`endif
    end
    o_req = imem_req; o_addr = imem_addr; o_valid = if_valid; o_pc = PC; o_insn = instruction;
    if (imem_req === 1'b1) memq.push_back('{due: cyc + lat, addr: imem_addr});
    if (r) begin
      m_fpc = RST_PC; mq.delete(); m_out = 0; m_fcnt = 0; m_dcnt = 0;
    end else begin
      keep = imem_rvalid && (m_out == 1) && !b;
      drp  = imem_rvalid && ((m_out == 2) || ((m_out == 1) && b));
      popd = e_valid && !s && !b;
      if (b) mq.delete();
      else begin
        if (popd) void'(mq.pop_front());
        if (keep) mq.push_back('{pc: m_rpc + 32'd4, insn: imem_rdata});
      end
      if (e_req) begin m_rpc = m_fpc; m_fcnt = m_fcnt + 32'd1; end
      if (drp) m_dcnt = m_dcnt + 32'd1;
      if (imem_rvalid && m_out != 0) m_out = 0;
      else if (e_req)                m_out = 1;
      else if (b && m_out == 1)      m_out = 2;
      if (b)          m_fpc = {tgt[31:2], 2'b00};
      else if (e_req) m_fpc = m_fpc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    memq.delete();
  endtask

  task automatic wait_req(input string nm, output logic [31:0] a);
    logic found;
    found = 1'b0; a = 32'h0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        step(1'b0, 1'b0, 1'b0, 32'h0);
        if (o_req) begin found = 1'b1; a = o_addr; end
      end
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout got=none want=request", nm);
    end
  endtask

  task automatic wait_valid(input string nm, output logic [31:0] p, output logic [31:0] ins);
    logic found;
    found = 1'b0; p = 32'h0; ins = 32'h0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        step(1'b0, 1'b0, 1'b0, 32'h0);
        if (o_valid) begin found = 1'b1; p = o_pc; ins = o_insn; end
      end
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout got=none want=if_valid", nm);
    end
  endtask

  initial begin : main
    int          rc[$];
    logic [31:0] ra[$], pcs[$], ins[$];
    logic [31:0] a, p, w, tgt;
    int          nreq;
    logic        got, r, s, b;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    m_fpc = RST_PC; m_rpc = RST_PC; m_out = 0; m_fcnt = 0; m_dcnt = 0;
    @(posedge clk); #1;
    chk_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_if_valid", 32'(o_valid), 32'h0);
    chk("rst_PC", o_pc, 32'h0);
    chk("rst_instruction", o_insn, 32'h0);
    chk("rst_imem_req", 32'(o_req), 32'h0);

    // Latency 1, free-running: issues every other cycle from RESET_PC.
    lat = 1; got = 1'b0; p = 32'h0; w = 32'h0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (o_req) begin rc.push_back(cyc); ra.push_back(o_addr); end
      if (o_valid && !got) begin got = 1'b1; p = o_pc; w = o_insn; end
    end
    chk("seq_nreq", 32'(ra.size()), 32'd6);
    if (ra.size() >= 3) begin
      chk("seq_addr0", ra[0], 32'h0);
      chk("seq_addr1", ra[1], 32'h4);
      chk("seq_addr2", ra[2], 32'h8);
      chk("seq_gap01", 32'(rc[1] - rc[0]), 32'd2);
      chk("seq_gap12", 32'(rc[2] - rc[1]), 32'd2);
    end
    chk("seq_first_PC", p, 32'h4);
    chk("seq_first_insn", w, 32'h5A5A_C3C3);

    // Stall from reset: queue fills to two, then no more requests.
    do_reset();
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (o_req) nreq++;
    end
    chk("stall_nreq", 32'(nreq), 32'd2);
    chk("stall_head_PC", o_pc, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("release_PC0", o_pc, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("release_PC1", o_pc, 32'h8);

    // Branch while a read is outstanding: old word dropped, fetch resumes at aligned target.
    lat = 3;
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("br_issue", 32'(o_req), 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    wait_req("br_next_req", a);
    chk("br_next_addr", a, 32'h0000_0100);
    wait_valid("br_next_valid", p, w);
    chk("br_next_PC", p, 32'h0000_0104);
    chk("br_next_insn", w, memf(32'h0000_0100));
`ifdef FETCH_PERF_CNT_EN
    chk("br_discard_count", discard_count, 32'd1);
`endif

    // Branch in the same cycle as the response.
    lat = 2;
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    chk("brrv_rvalid_seen", 32'(imem_rvalid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("brrv_empty", 32'(o_valid), 32'h0);
    chk("brrv_req", 32'(o_req), 32'h1);
    chk("brrv_addr", o_addr, 32'h0000_0040);
    wait_valid("brrv_valid", p, w);
    chk("brrv_PC", p, 32'h0000_0044);
    chk("brrv_insn", w, memf(32'h0000_0040));
`ifdef FETCH_PERF_CNT_EN
    chk("brrv_discard_count", discard_count, 32'd1);
`endif

    // Fetch address wrap at the top of the address space.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    ra.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (o_req) ra.push_back(o_addr);
      if (o_valid) begin pcs.push_back(o_pc); ins.push_back(o_insn); end
    end
    chk("wrap_nreq_ge2", 32'(ra.size() >= 2), 32'h1);
    chk("wrap_nout_ge2", 32'(pcs.size() >= 2), 32'h1);
    if (ra.size() >= 2) begin
      chk("wrap_addr0", ra[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", ra[1], 32'h0);
    end
    if (pcs.size() >= 2) begin
      chk("wrap_PC0", pcs[0], 32'h0);
      chk("wrap_PC1", pcs[1], 32'h4);
      chk("wrap_insn0", ins[0], memf(32'hFFFF_FFFC));
    end

    // Reset while waiting; the stale response lands in IDLE and is ignored.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rw_rst_req", 32'(o_req), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rw_late_rvalid", 32'(imem_rvalid), 32'h1);
    chk("rw_if_valid", 32'(o_valid), 32'h0);
    chk("rw_PC", o_pc, 32'h0);
    chk("rw_instruction", o_insn, 32'h0);
    chk("rw_req", 32'(o_req), 32'h1);
    chk("rw_addr", o_addr, RST_PC);
    wait_valid("rw_valid", p, w);
    chk("rw_first_PC", p, RST_PC + 32'd4);
    chk("rw_first_insn", w, memf(RST_PC));

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if (memq.size() == 0 && $urandom_range(0, 19) == 0) lat = $urandom_range(1, 4);
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 9) < 3);
      b   = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | {28'h0, tgt[3:0]};
      step(r, s, b, tgt);
      if (r) memq.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
